// File: rtl/r2sdf_bf_stage.sv
// r2sdf_bf_stage: radix-2 single-delay-feedback butterfly stage for a
// streaming 2^N-point FFT. One complex sample per clock; stage n holds a
// D = 2^(n-1) deep feedback delay line.
//
// Pipeline: stage 1 tracks the frame counter and rotates the incoming
// sample by its twiddle; stage 2 runs the butterfly against the delay-line
// head and registers the output.
//
// Optional feature macro: BF_STAGE_SCALE_EN
//   defined   -> sum/difference are halved (arithmetic shift right by 1)
//   undefined -> sum/difference are saturated to W bits
// Twiddle products are saturated to W bits in both builds.
module r2sdf_bf_stage #(
  parameter int N = 3,
  parameter int n = 1,
  parameter int W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_ip,
  input  logic [W-1:0]            ip_re,
  input  logic [W-1:0]            ip_im,
  input  logic [W*(2**(N-1))-1:0] cos_arr,
  input  logic [W*(2**(N-1))-1:0] sin_arr,
  output logic [W-1:0]            op_re,
  output logic [W-1:0]            op_im,
  output logic                    start_op
);

  localparam int D  = 1 << (n - 1);
  localparam int TW = 1 << (N - 1);
  localparam int TI = (N > 1) ? N - 1 : 1;
  localparam logic [N-1:0] CNT_ONE = N'(1);
  localparam logic [N-1:0] CNT_D   = N'(D);

  // Clamp a twiddle accumulator (already shifted down) to W bits.
  function automatic logic [W-1:0] sat_acc(input logic [2*W:0] x);
    logic hi_ones;
    logic hi_zeros;
    hi_ones  = &x[2*W:W-1];
    hi_zeros = ~|x[2*W:W-1];
    if (hi_ones | hi_zeros) begin
      sat_acc = x[W-1:0];
    end else if (x[2*W]) begin
      sat_acc = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat_acc = {1'b0, {(W-1){1'b1}}};
    end
  endfunction

  // Clamp a (W+1)-bit butterfly result to W bits. In the scaled build the
  // value has already been halved, so this never clips there.
  function automatic logic [W-1:0] sat_bf(input logic [W:0] x);
    if (x[W] == x[W-1]) begin
      sat_bf = x[W-1:0];
    end else if (x[W]) begin
      sat_bf = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat_bf = {1'b0, {(W-1){1'b1}}};
    end
  endfunction

  // ------------------------------------------------------------------
  // Twiddle tables unpacked into arrays for indexed lookup
  // ------------------------------------------------------------------
  logic [W-1:0] w_cos_tab [TW];
  logic [W-1:0] w_sin_tab [TW];

  generate
    for (genvar gi = 0; gi < TW; gi++) begin : g_tab
      assign w_cos_tab[gi] = cos_arr[gi*W +: W];
      assign w_sin_tab[gi] = sin_arr[gi*W +: W];
    end
  endgenerate

  // ------------------------------------------------------------------
  // Stage 1: frame counter, arming, twiddle rotation
  // ------------------------------------------------------------------
  logic [N-1:0]  r_cnt;
  logic          r_armed;
  logic          r_first;
  logic [W-1:0]  r_ip_re;
  logic [W-1:0]  r_ip_im;
  logic [W-1:0]  r_b_re;
  logic [W-1:0]  r_b_im;

  logic [N-1:0]  w_cnt;
  logic          w_armed;
  logic          w_first;
  logic [TI-1:0] w_kidx;

  // Count for the sample on the inputs right now: start_ip forces 0, the
  // counter holds at 0 until the first start_ip arms the block. w_first
  // stays set from a start_ip until the counter wraps without one, so
  // start_op only fires for frames that were actually started.
  always_comb begin
    w_armed = r_armed | start_ip;
    if (start_ip) begin
      w_cnt = '0;
    end else if (r_armed) begin
      w_cnt = r_cnt + CNT_ONE;
    end else begin
      w_cnt = '0;
    end
    w_first = start_ip | (r_first & (w_cnt != '0));
  end

  // Twiddle index k = c mod D; stage 1 always uses entry 0.
  generate
    if (n > 1) begin : g_k
      if (n - 1 < TI) begin : g_ext
        assign w_kidx = {{(TI-n+1){1'b0}}, w_cnt[n-2:0]};
      end else begin : g_full
        assign w_kidx = w_cnt[n-2:0];
      end
    end else begin : g_k0
      assign w_kidx = '0;
    end
  endgenerate

  logic signed [2*W-1:0] w_xr;
  logic signed [2*W-1:0] w_xi;
  logic signed [2*W-1:0] w_c;
  logic signed [2*W-1:0] w_s;
  logic signed [2*W-1:0] w_p_rc;
  logic signed [2*W-1:0] w_p_is;
  logic signed [2*W-1:0] w_p_ic;
  logic signed [2*W-1:0] w_p_rs;
  logic signed [2*W:0]   w_acc_re;
  logic signed [2*W:0]   w_acc_im;
  logic signed [2*W:0]   w_sh_re;
  logic signed [2*W:0]   w_sh_im;
  logic [W-1:0]          w_b_re;
  logic [W-1:0]          w_b_im;

  // b = x * (cos - j sin): full-precision products, sum, then drop the
  // Q2.(W-2) fraction bits by arithmetic shift (truncation, no rounding).
  always_comb begin
    w_xr     = {{W{ip_re[W-1]}}, ip_re};
    w_xi     = {{W{ip_im[W-1]}}, ip_im};
    w_c      = {{W{w_cos_tab[w_kidx][W-1]}}, w_cos_tab[w_kidx]};
    w_s      = {{W{w_sin_tab[w_kidx][W-1]}}, w_sin_tab[w_kidx]};
    w_p_rc   = w_xr * w_c;
    w_p_is   = w_xi * w_s;
    w_p_ic   = w_xi * w_c;
    w_p_rs   = w_xr * w_s;
    w_acc_re = {w_p_rc[2*W-1], w_p_rc} + {w_p_is[2*W-1], w_p_is};
    w_acc_im = {w_p_ic[2*W-1], w_p_ic} - {w_p_rs[2*W-1], w_p_rs};
    w_sh_re  = w_acc_re >>> (W - 2);
    w_sh_im  = w_acc_im >>> (W - 2);
    w_b_re   = sat_acc(w_sh_re);
    w_b_im   = sat_acc(w_sh_im);
  end

  // Stage-1 registers: counter state plus the raw and rotated sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_first <= 1'b0;
      r_ip_re <= '0;
      r_ip_im <= '0;
      r_b_re  <= '0;
      r_b_im  <= '0;
    end else begin
      r_cnt   <= w_cnt;
      r_armed <= w_armed;
      r_first <= w_first;
      r_ip_re <= ip_re;
      r_ip_im <= ip_im;
      r_b_re  <= w_b_re;
      r_b_im  <= w_b_im;
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: butterfly against the delay-line head
  // ------------------------------------------------------------------
  logic [W-1:0] r_fifo_re [D];
  logic [W-1:0] r_fifo_im [D];

  logic               w_bfly;
  logic [W-1:0]       w_head_re;
  logic [W-1:0]       w_head_im;
  logic signed [W:0]  w_sum_re;
  logic signed [W:0]  w_sum_im;
  logic signed [W:0]  w_dif_re;
  logic signed [W:0]  w_dif_im;
  logic signed [W:0]  w_rsum_re;
  logic signed [W:0]  w_rsum_im;
  logic signed [W:0]  w_rdif_re;
  logic signed [W:0]  w_rdif_im;
  logic [W-1:0]       w_push_re;
  logic [W-1:0]       w_push_im;
  logic [W-1:0]       w_nop_re;
  logic [W-1:0]       w_nop_im;
  logic               w_sop;

  // Butterfly datapath and the phase mux: fill phase forwards the stored
  // difference and stores the input; butterfly phase emits a+b, stores a-b.
  always_comb begin
    w_bfly    = r_cnt[n-1];
    w_head_re = r_fifo_re[D-1];
    w_head_im = r_fifo_im[D-1];
    w_sum_re  = {w_head_re[W-1], w_head_re} + {r_b_re[W-1], r_b_re};
    w_sum_im  = {w_head_im[W-1], w_head_im} + {r_b_im[W-1], r_b_im};
    w_dif_re  = {w_head_re[W-1], w_head_re} - {r_b_re[W-1], r_b_re};
    w_dif_im  = {w_head_im[W-1], w_head_im} - {r_b_im[W-1], r_b_im};
`ifdef BF_STAGE_SCALE_EN
    w_rsum_re = w_sum_re >>> 1;
    w_rsum_im = w_sum_im >>> 1;
    w_rdif_re = w_dif_re >>> 1;
    w_rdif_im = w_dif_im >>> 1;
`else
    w_rsum_re = w_sum_re;
    w_rsum_im = w_sum_im;
    w_rdif_re = w_dif_re;
    w_rdif_im = w_dif_im;
`endif
    if (w_bfly) begin
      w_push_re = sat_bf(w_rdif_re);
      w_push_im = sat_bf(w_rdif_im);
      w_nop_re  = sat_bf(w_rsum_re);
      w_nop_im  = sat_bf(w_rsum_im);
    end else begin
      w_push_re = r_ip_re;
      w_push_im = r_ip_im;
      w_nop_re  = w_head_re;
      w_nop_im  = w_head_im;
    end
    w_sop = r_armed & r_first & (r_cnt == CNT_D);
  end

  // Delay line: shifts exactly once per armed cycle, so the head is always
  // the value pushed D samples earlier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        r_fifo_re[i] <= '0;
        r_fifo_im[i] <= '0;
      end
    end else if (r_armed) begin
      r_fifo_re[0] <= w_push_re;
      r_fifo_im[0] <= w_push_im;
      for (int i = 1; i < D; i++) begin
        r_fifo_re[i] <= r_fifo_re[i-1];
        r_fifo_im[i] <= r_fifo_im[i-1];
      end
    end
  end

  // Output register; held at zero until the block is armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_re    <= '0;
      op_im    <= '0;
      start_op <= 1'b0;
    end else begin
      op_re    <= r_armed ? w_nop_re : '0;
      op_im    <= r_armed ? w_nop_im : '0;
      start_op <= w_sop;
    end
  end

endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// Bench for r2sdf_bf_stage: stages n=1,2,3 of an 8-point FFT run side by
// side on the same input stream and are compared every cycle against a
// stream-level model of what an R2SDF stage produces.
module tb_r2sdf_bf_stage;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int TW = 4;
  localparam int NS = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_ip;
  logic [W-1:0]    ip_re;
  logic [W-1:0]    ip_im;
  logic [W*TW-1:0] cos_arr;
  logic [W*TW-1:0] sin_arr;
  logic [W-1:0]    op_re [NS];
  logic [W-1:0]    op_im [NS];
  logic            start_op [NS];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: twiddle tables and the input stream since the block armed.
  int cos_t [TW];
  int sin_t [TW];
  int hist_re [$];
  int hist_im [$];
  bit hist_st [$];
  bit armed;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_dut
      r2sdf_bf_stage #(.N(N), .n(gi + 1), .W(W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start_ip (start_ip),
        .ip_re    (ip_re),
        .ip_im    (ip_im),
        .cos_arr  (cos_arr),
        .sin_arr  (sin_arr),
        .op_re    (op_re[gi]),
        .op_im    (op_im[gi]),
        .start_op (start_op[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int reduce(input int v);
`ifdef BF_STAGE_SCALE_EN
    return v >>> 1;
`else
    return sat(longint'(v));
`endif
  endfunction

  function automatic int rnd16();
    logic [15:0] t;
    t = 16'($urandom);
    return int'($signed(t));
  endfunction

  task automatic load_tables();
    for (int k = 0; k < TW; k++) begin
      cos_arr[k*W +: W] = cos_t[k][W-1:0];
      sin_arr[k*W +: W] = sin_t[k][W-1:0];
    end
  endtask

  // Expected output of stage sn for stream position q. Within each block
  // of 2D samples, positions D..2D-1 emit x[q-D] + W^k x[q]; positions
  // 0..D-1 emit the differences of the previous block (0 if none yet).
  function automatic void exp_out(input int sn, input int q,
                                  output int er, output int ei, output int es);
    int d, p, k, ar, ai, xr, xi, br, bi;
    longint c, s;
    d  = 1 << (sn - 1);
    er = 0; ei = 0; es = 0;
    if (q < 0) return;
    p = q % (2 * d);
    k = q % d;
    if (q - d >= 0) es = int'(hist_st[q - d]);
    if (p >= d) begin
      ar = hist_re[q - d]; ai = hist_im[q - d];
      xr = hist_re[q];     xi = hist_im[q];
    end else if (q >= 2 * d) begin
      ar = hist_re[q - 2*d]; ai = hist_im[q - 2*d];
      xr = hist_re[q - d];   xi = hist_im[q - d];
    end else begin
      return;
    end
    c  = longint'(cos_t[k]);
    s  = longint'(sin_t[k]);
    br = sat((xr * c + xi * s) >>> (W - 2));
    bi = sat((xi * c - xr * s) >>> (W - 2));
    if (p >= d) begin
      er = reduce(ar + br); ei = reduce(ai + bi);
    end else begin
      er = reduce(ar - br); ei = reduce(ai - bi);
    end
  endfunction

  // One clock of stimulus, then compare all stages at the falling edge.
  task automatic cycle(input bit st, input int xr, input int xi);
    int q, er, ei, es;
    start_ip = st;
    ip_re    = xr[W-1:0];
    ip_im    = xi[W-1:0];
    @(posedge clk);
    if (st) armed = 1'b1;
    if (armed) begin
      hist_re.push_back(xr);
      hist_im.push_back(xi);
      hist_st.push_back(st);
    end
    q = hist_re.size() - 2;
    @(negedge clk);
    $display("t=%0t st=%0b in=(%0d,%0d) q=%0d s1=(%0d,%0d,%0b) s2=(%0d,%0d,%0b) s3=(%0d,%0d,%0b)",
             $time, st, xr, xi, q,
             $signed(op_re[0]), $signed(op_im[0]), start_op[0],
             $signed(op_re[1]), $signed(op_im[1]), start_op[1],
             $signed(op_re[2]), $signed(op_im[2]), start_op[2]);
    for (int i = 0; i < NS; i++) begin
      exp_out(i + 1, q, er, ei, es);
      check($sformatf("s%0d_re q=%0d", i + 1, q), int'($signed(op_re[i])), er);
      check($sformatf("s%0d_im q=%0d", i + 1, q), int'($signed(op_im[i])), ei);
      check($sformatf("s%0d_sop q=%0d", i + 1, q), int'(start_op[i]), es);
    end
  endtask

  task automatic frame_rand(input bit st);
    cycle(st, rnd16(), rnd16());
    repeat (7) cycle(1'b0, rnd16(), rnd16());
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NS; i++) begin
      check($sformatf("%s s%0d_re", tag, i + 1), int'($signed(op_re[i])), 0);
      check($sformatf("%s s%0d_im", tag, i + 1), int'($signed(op_im[i])), 0);
      check($sformatf("%s s%0d_sop", tag, i + 1), int'(start_op[i]), 0);
    end
  endtask

  // Reset asserted between clock edges: outputs must clear without a clock.
  task automatic mid_reset();
    #2;
    rst      = 1'b1;
    start_ip = 1'b0;
    #1;
    check_zero("rst_async");
    armed = 1'b0;
    hist_re.delete();
    hist_im.delete();
    hist_st.delete();
    cos_t[0] = 16384;
    sin_t[0] = 0;
    for (int k = 1; k < TW; k++) begin
      cos_t[k] = int'($urandom_range(32768)) - 16384;
      sin_t[k] = int'($urandom_range(32768)) - 16384;
    end
    load_tables();
    @(posedge clk);
    @(negedge clk);
    check_zero("rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start_ip = 1'b0;
    ip_re    = '0;
    ip_im    = '0;
    armed    = 1'b0;
    cos_t[0] = 16384;  sin_t[0] = 0;
    cos_t[1] = 0;      sin_t[1] = 16384;
    cos_t[2] = 11585;  sin_t[2] = 11585;
    cos_t[3] = -11585; sin_t[3] = 11585;
    load_tables();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Unarmed: random inputs must not reach the outputs.
    repeat (6) cycle(1'b0, rnd16(), rnd16());

    // Directed frames, back to back.
    cycle(1'b1, 1000, 0); cycle(1'b0, 200, 0); cycle(1'b0, 50, 0); cycle(1'b0, 10, 0);
    repeat (4) cycle(1'b0, 0, 0);
    cycle(1'b1, 0, 0); cycle(1'b0, 0, 0); cycle(1'b0, 0, 0); cycle(1'b0, 1000, 0);
    repeat (4) cycle(1'b0, 0, 0);
    cycle(1'b1, 32767, 0); cycle(1'b0, 32767, 0); cycle(1'b0, -32768, -32768);
    cycle(1'b0, -32768, -32768); cycle(1'b0, 32767, 32767); cycle(1'b0, -32768, 32767);
    cycle(1'b0, 32767, -32768); cycle(1'b0, -32768, 32767);

    // Random back-to-back frames, one frame continuing without start_ip.
    repeat (4) frame_rand(1'b1);
    frame_rand(1'b0);
    frame_rand(1'b1);

    // Reset two cycles into a frame, then idle, then resume.
    cycle(1'b1, rnd16(), rnd16());
    cycle(1'b0, rnd16(), rnd16());
    mid_reset();
    repeat (5) cycle(1'b0, rnd16(), rnd16());
    repeat (4) frame_rand(1'b1);
    repeat (8) cycle(1'b0, rnd16(), rnd16());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/r2sdf_bf_stage.md
# r2sdf_bf_stage

Radix-2 single-delay-feedback (R2SDF) butterfly stage for the streaming FFT pipeline. It takes one complex sample per clock and runs a 2-point butterfly against a sample held in a feedback delay line. Before each sum, it applies a twiddle rotation to the incoming operand. N instances, with stage index n = 1..N, are chained start-to-start to form a 2^N-point FFT. Output reordering is done outside this block.

## Interface
- N, 3: log2 of FFT frame length (frame = 2^N samples).
- n, 1: stage index, 1..N; delay length D = 2^(n-1).
- W, 16: signed two's-complement width of each real/imag component.
- clk  input  1  rising-edge clock; one clock domain.
- rst  input  1  reset, asynchronous and active-high.
- start_ip  input  1  one-cycle pulse marking the first sample of an input frame.
- ip_re, ip_im  input  W each  input sample.
- cos_arr, sin_arr  input  W·2^(N-1) each  twiddle tables, flattened, entry k at bits [k·W +: W].
  - Format Q2.(W-2), so 1.0 = 2^(W-2).
  - Only entries 0..D-1 are used.
- op_re, op_im  output  W each  registered output sample.
- start_op  output  1  registered one-cycle pulse marking the first output sample of a frame.

## Operation
- Frame counter c, N bits.
  - start_ip=1 loads c=0 for the current sample.
  - Otherwise c increments by 1 each cycle, wrapping modulo 2^N.
- Block is armed by the first start_ip after reset. While unarmed, the delay line is not written and outputs stay 0.
- Phase is selected by bit (n-1) of c:
  - Fill (bit=0):
    - Input is pushed into the D-deep FIFO delay line.
    - Output register takes the FIFO head, which is the difference from the previous butterfly phase. It is 0 after reset.
  - Butterfly (bit=1):
    - a = FIFO head.
    - b = input × Wk, where k = c mod D and Wk = cos_arr[k] − j·sin_arr[k].
    - b_re = (ip_re·cos + ip_im·sin) >>> (W-2); b_im = (ip_im·cos − ip_re·sin) >>> (W-2).
    - Multiply is full 2W-bit, then the shift; no rounding.
    - Output register takes a+b; a−b is pushed into the FIFO.
- Add/sub is computed at W+1 bits, then reduced to W bits per the Configuration section.
- n=1: D=1, k is always 0, so the twiddle is trivially 1.
- start_ip during a running frame restarts c=0 immediately. FIFO contents are kept; that partial frame's outputs are don't-care.
- Back-to-back frames with no gap are supported: the next start_ip coincides with the counter wrap.

## Timing
- Throughput: one sample per clock, no stalls, no ready/valid.
- Latency: the first output of a frame (a+b for k=0) appears D+1 cycles after the cycle start_ip was sampled.
- start_op is high in exactly that cycle.
- Per frame, output order is: sum(k=0..D-1), then diff(k=0..D-1), repeating every 2D cycles.
- Reset, including mid-frame, immediately:
  - op_re, op_im, start_op, c, FIFO and armed all go to 0.
  - Any pending start_op pulse is cancelled.
  - Operation resumes at the next start_ip.

## Configuration
- BF_STAGE_SCALE_EN defined:
  - Sum and difference are arithmetically shifted right by 1 (divide by 2, truncate toward −∞).
  - Cannot overflow.
- BF_STAGE_SCALE_EN undefined:
  - Sum and difference are saturated to [−2^(W-1), 2^(W-1)−1].
  - Twiddle products are also saturated to W bits.

## Test plan
All scenarios use N=3, W=16, cos_arr[0]=16384, sin_arr[0]=0.
- Stage n=1, scale enabled, start_ip with x0=(1000,0), x1=(200,0), x2=(50,0), x3=(10,0) -> op (600,0) with start_op=1 at t0+2; then (400,0), (30,0), (20,0).
- Stage n=2, scale enabled, cos_arr[1]=0, sin_arr[1]=16384, inputs x0..x3 = (0,0),(0,0),(0,0),(1000,0) -> at t0+3 start_op=1; outputs (0,0), (0,-500), (0,0), (0,500).
- Scale disabled, n=1, x0=(32767,0), x1=(32767,0) -> op (32767,0) saturated; following output (0,0).
- Reset asserted two cycles into a frame -> op, start_op go to 0 asynchronously; no start_op until the next start_ip, then latency is again D+1.
- Two back-to-back 8-sample frames, n=3 (D=4) -> start_op pulses exactly at t0+5 and t0+13; second frame's results are unaffected by the first.
- Outputs before any start_ip after reset, with random ip -> op stays (0,0), start_op stays 0.
